// File: rtl/x_result_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | x_arb_pkg: shared result types and round-robin helper              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package x_arb_pkg;

   localparam int X_ID_WIDTH   = 4;
   localparam int X_DATA_WIDTH = 32;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0]   id;
      logic [4:0]              rd;
      logic                    we;
      logic [X_DATA_WIDTH-1:0] data;
   } x_result_t;

   // Wraps at n rather than at a power of two, so odd requester counts stay in range.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/x_result_arbiter_if.sv
// +--------------------------------------------------------------------+
// | x_result_arbiter_if: coprocessor result ports and core result port |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface x_result_arbiter_if #(
   parameter int NUM_COPROC = 2,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 4
);
   localparam int IDX_W = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;

   logic [NUM_COPROC-1:0]        req_valid_i;
   logic [NUM_COPROC-1:0]        req_ready_o;
   logic [NUM_COPROC*ID_W-1:0]   req_id_i;
   logic [NUM_COPROC*5-1:0]      req_rd_i;
   logic [NUM_COPROC-1:0]        req_we_i;
   logic [NUM_COPROC*DATA_W-1:0] req_data_i;

   logic                         x_result_valid_o;
   logic                         x_result_ready_i;
   logic [ID_W-1:0]              x_result_id_o;
   logic [4:0]                   x_result_rd_o;
   logic                         x_result_we_o;
   logic [DATA_W-1:0]            x_result_data_o;
   logic [IDX_W-1:0]             x_result_src_o;
   logic                         busy_o;

   modport slave (
      input  req_valid_i, req_id_i, req_rd_i, req_we_i, req_data_i, x_result_ready_i,
      output req_ready_o, x_result_valid_o, x_result_id_o, x_result_rd_o,
             x_result_we_o, x_result_data_o, x_result_src_o, busy_o
   );

   modport master (
      output req_valid_i, req_id_i, req_rd_i, req_we_i, req_data_i, x_result_ready_i,
      input  req_ready_o, x_result_valid_o, x_result_id_o, x_result_rd_o,
             x_result_we_o, x_result_data_o, x_result_src_o, busy_o
   );

endinterface

`default_nettype wire

// File: rtl/x_result_arbiter_rr_arbiter_core.sv
// +--------------------------------------------------------------------+
// | rr_arbiter_core: combinational round-robin scan from a pointer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter_core #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  wire logic [N-1:0]     i_req,
   input  wire logic [IDX_W-1:0] i_ptr,
   output logic      [N-1:0]     o_gnt,
   output logic      [IDX_W-1:0] o_gnt_idx,
   output logic                  o_any
);

   int               w_idx;
   logic [IDX_W-1:0] w_sel;

   // First requester at or after the pointer wins; i_ptr is assumed < N.
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      w_idx     = 0;
      w_sel     = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end
         w_sel = IDX_W'(w_idx);
         if (!o_any && i_req[w_sel]) begin
            o_any        = 1'b1;
            o_gnt[w_sel] = 1'b1;
            o_gnt_idx    = w_sel;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/x_result_arbiter.sv
// +--------------------------------------------------------------------+
// | x_result_arbiter: round-robin share of the core X result channel   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module x_result_arbiter
   import x_arb_pkg::*;
#(
   parameter int NUM_COPROC = 2,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 4
) (
   input wire logic          clk_i,
   input wire logic          rst_i,
   x_result_arbiter_if.slave bus
);

   localparam int IDX_W = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;

   logic [NUM_COPROC-1:0] w_gnt;
   logic [IDX_W-1:0]      w_gnt_idx;
   logic                  w_any;
   logic                  w_can_load;
   logic                  w_load;

   logic [IDX_W-1:0]      r_ptr;
   logic                  r_valid;
   logic [ID_W-1:0]       r_id;
   logic [4:0]            r_rd;
   logic                  r_we;
   logic [DATA_W-1:0]     r_data;
   logic [IDX_W-1:0]      r_src;

   rr_arbiter_core #(
      .N     (NUM_COPROC),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_req     (bus.req_valid_i),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   assign w_can_load = ~r_valid | bus.x_result_ready_i;
   assign w_load     = w_can_load & w_any;

   // Ready is held low during reset so no coprocessor sees a handshake that gets discarded.
   assign bus.req_ready_o = (w_load && !rst_i) ? w_gnt : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
         r_rd    <= '0;
         r_we    <= 1'b0;
         r_data  <= '0;
         r_src   <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_id    <= bus.req_id_i[32'(w_gnt_idx)*ID_W +: ID_W];
         r_rd    <= bus.req_rd_i[32'(w_gnt_idx)*5 +: 5];
         r_we    <= bus.req_we_i[w_gnt_idx];
         r_data  <= bus.req_data_i[32'(w_gnt_idx)*DATA_W +: DATA_W];
         r_src   <= w_gnt_idx;
         r_ptr   <= IDX_W'(rr_next(32'(w_gnt_idx), 32'(NUM_COPROC)));
      end else if (bus.x_result_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.x_result_valid_o = r_valid;
   assign bus.x_result_id_o    = r_id;
   assign bus.x_result_rd_o    = r_rd;
   assign bus.x_result_we_o    = r_we;
   assign bus.x_result_data_o  = r_data;
   assign bus.x_result_src_o   = r_src;
   assign bus.busy_o           = r_valid | (|bus.req_valid_i);

endmodule

`default_nettype wire

// File: tb/tb_x_result_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_x_result_arbiter: scenario tasks plus scoreboarded random run   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_x_result_arbiter;
   import x_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   typedef struct packed {
      x_result_t r;
      logic      src;
   } item_t;

   item_t sb_q[$];

   x_result_arbiter_if #(.NUM_COPROC(2), .DATA_W(32), .ID_W(4)) bus2();
   x_result_arbiter_if #(.NUM_COPROC(3), .DATA_W(32), .ID_W(4)) bus3();

   x_result_arbiter #(.NUM_COPROC(2), .DATA_W(32), .ID_W(4)) dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus2)
   );

   x_result_arbiter #(.NUM_COPROC(3), .DATA_W(32), .ID_W(4)) dut3 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane2(input int i, input logic [3:0] id, input logic [4:0] rd,
                            input logic we, input logic [31:0] d);
      bus2.req_id_i[i*4 +: 4]    = id;
      bus2.req_rd_i[i*5 +: 5]    = rd;
      bus2.req_we_i[i]           = we;
      bus2.req_data_i[i*32 +: 32] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus2.req_valid_i = '0;
      bus2.x_result_ready_i = 1'b1;
      bus3.req_valid_i = '0;
      bus3.x_result_ready_i = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      bus2.req_valid_i = 2'b11;
      set_lane2(0, 4'h1, 5'd1, 1'b1, 32'h1111_1111);
      set_lane2(1, 4'h2, 5'd2, 1'b1, 32'h2222_2222);
      bus2.x_result_ready_i = 1'b0;
      step();
      step();
      total++;
      if (bus2.x_result_valid_o !== 1'b1) begin
         bad++; $display("FAIL reset_pre_valid got=%b exp=1", bus2.x_result_valid_o);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus2.x_result_valid_o !== 1'b0) begin
         bad++; $display("FAIL reset_async_valid got=%b exp=0", bus2.x_result_valid_o);
      end
      total++;
      if ({bus2.x_result_id_o, bus2.x_result_rd_o, bus2.x_result_we_o,
           bus2.x_result_data_o, bus2.x_result_src_o} !== '0) begin
         bad++; $display("FAIL reset_payload got id=%h rd=%0d data=%h src=%0d exp zeros",
                         bus2.x_result_id_o, bus2.x_result_rd_o, bus2.x_result_data_o, bus2.x_result_src_o);
      end
      total++;
      if (bus2.req_ready_o !== 2'b00) begin
         bad++; $display("FAIL reset_req_ready got=%b exp=00", bus2.req_ready_o);
      end
      step();
      rst = 1'b0;
      bus2.x_result_ready_i = 1'b1;
      #1;
      total++;
      if (bus2.req_ready_o !== 2'b01) begin
         bad++; $display("FAIL reset_first_grant got=%b exp=01", bus2.req_ready_o);
      end
   endtask

   task automatic test_alternate();
      logic [1:0]  exp_rr;
      logic [31:0] exp_d;
      do_reset();
      bus2.req_valid_i = 2'b11;
      set_lane2(0, 4'hA, 5'd10, 1'b1, 32'hAAAA_0000);
      set_lane2(1, 4'hB, 5'd11, 1'b0, 32'hBBBB_0001);
      bus2.x_result_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         exp_rr = (c % 2 == 0) ? 2'b01 : 2'b10;
         exp_d  = (c % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001;
         #1;
         total++;
         if (bus2.req_ready_o !== exp_rr) begin
            bad++; $display("FAIL alt_req_ready c=%0d got=%b exp=%b", c, bus2.req_ready_o, exp_rr);
         end
         step();
         total++;
         if (bus2.x_result_valid_o !== 1'b1 || bus2.x_result_src_o !== 1'(c % 2)
             || bus2.x_result_data_o !== exp_d) begin
            bad++; $display("FAIL alt_output c=%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                            c, bus2.x_result_valid_o, bus2.x_result_src_o, bus2.x_result_data_o, c % 2, exp_d);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      bus2.req_valid_i = 2'b10;
      set_lane2(0, 4'hF, 5'd31, 1'b1, 32'h0BAD_F00D);
      set_lane2(1, 4'h3, 5'd7, 1'b1, 32'hDEAD_BEEF);
      bus2.x_result_ready_i = 1'b1;
      #1;
      total++;
      if (bus2.req_ready_o !== 2'b10) begin
         bad++; $display("FAIL single_req_ready got=%b exp=10", bus2.req_ready_o);
      end
      step();
      bus2.req_valid_i = 2'b00;
      total++;
      if (bus2.x_result_valid_o !== 1'b1 || bus2.x_result_id_o !== 4'h3 || bus2.x_result_rd_o !== 5'd7
          || bus2.x_result_we_o !== 1'b1 || bus2.x_result_data_o !== 32'hDEAD_BEEF
          || bus2.x_result_src_o !== 1'b1) begin
         bad++; $display("FAIL single_output got v=%b id=%h rd=%0d we=%b data=%h src=%0d exp v=1 id=3 rd=7 we=1 data=deadbeef src=1",
                         bus2.x_result_valid_o, bus2.x_result_id_o, bus2.x_result_rd_o,
                         bus2.x_result_we_o, bus2.x_result_data_o, bus2.x_result_src_o);
      end
      total++;
      if (bus2.busy_o !== 1'b1) begin
         bad++; $display("FAIL single_busy_held got=%b exp=1", bus2.busy_o);
      end
      step();
      total++;
      if (bus2.x_result_valid_o !== 1'b0 || bus2.x_result_data_o !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL single_drain got v=%b data=%h exp v=0 data=deadbeef",
                         bus2.x_result_valid_o, bus2.x_result_data_o);
      end
      total++;
      if (bus2.busy_o !== 1'b0) begin
         bad++; $display("FAIL single_busy_idle got=%b exp=0", bus2.busy_o);
      end
   endtask

   task automatic test_stall();
      do_reset();
      bus2.req_valid_i = 2'b11;
      set_lane2(0, 4'h4, 5'd4, 1'b1, 32'hA000_0000);
      set_lane2(1, 4'h5, 5'd5, 1'b0, 32'hB111_1111);
      bus2.x_result_ready_i = 1'b1;
      #1;
      total++;
      if (bus2.req_ready_o !== 2'b01) begin
         bad++; $display("FAIL stall_first_grant got=%b exp=01", bus2.req_ready_o);
      end
      step();
      bus2.x_result_ready_i = 1'b0;
      set_lane2(0, 4'h6, 5'd6, 1'b1, 32'hCCCC_CCCC);
      for (int c = 0; c < 5; c++) begin
         #1;
         total++;
         if (bus2.req_ready_o !== 2'b00) begin
            bad++; $display("FAIL stall_req_ready c=%0d got=%b exp=00", c, bus2.req_ready_o);
         end
         total++;
         if (bus2.x_result_valid_o !== 1'b1 || bus2.x_result_src_o !== 1'b0
             || bus2.x_result_id_o !== 4'h4 || bus2.x_result_data_o !== 32'hA000_0000) begin
            bad++; $display("FAIL stall_hold c=%0d got v=%b src=%0d id=%h data=%h exp v=1 src=0 id=4 data=a0000000",
                            c, bus2.x_result_valid_o, bus2.x_result_src_o, bus2.x_result_id_o, bus2.x_result_data_o);
         end
         step();
      end
      bus2.x_result_ready_i = 1'b1;
      #1;
      total++;
      if (bus2.req_ready_o !== 2'b10) begin
         bad++; $display("FAIL stall_resume_grant got=%b exp=10", bus2.req_ready_o);
      end
      step();
      total++;
      if (bus2.x_result_src_o !== 1'b1 || bus2.x_result_data_o !== 32'hB111_1111 || bus2.x_result_we_o !== 1'b0) begin
         bad++; $display("FAIL stall_resume_output got src=%0d data=%h we=%b exp src=1 data=b1111111 we=0",
                         bus2.x_result_src_o, bus2.x_result_data_o, bus2.x_result_we_o);
      end
   endtask

   task automatic test_wrap3();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus3.req_id_i[i*4 +: 4]     = 4'(i + 8);
         bus3.req_rd_i[i*5 +: 5]     = 5'(i + 20);
         bus3.req_we_i[i]            = 1'b1;
         bus3.req_data_i[i*32 +: 32] = 32'h3000_0000 + 32'(i);
      end
      bus3.x_result_ready_i = 1'b1;
      bus3.req_valid_i = 3'b100;
      #1;
      total++;
      if (bus3.req_ready_o !== 3'b100) begin
         bad++; $display("FAIL wrap_grant2 got=%b exp=100", bus3.req_ready_o);
      end
      step();
      bus3.req_valid_i = 3'b011;
      total++;
      if (bus3.x_result_src_o !== 2'd2 || bus3.x_result_data_o !== 32'h3000_0002) begin
         bad++; $display("FAIL wrap_out2 got src=%0d data=%h exp src=2 data=30000002",
                         bus3.x_result_src_o, bus3.x_result_data_o);
      end
      #1;
      total++;
      if (bus3.req_ready_o !== 3'b001) begin
         bad++; $display("FAIL wrap_grant0 got=%b exp=001", bus3.req_ready_o);
      end
      step();
      total++;
      if (bus3.x_result_src_o !== 2'd0 || bus3.x_result_id_o !== 4'h8) begin
         bad++; $display("FAIL wrap_out0 got src=%0d id=%h exp src=0 id=8", bus3.x_result_src_o, bus3.x_result_id_o);
      end
      #1;
      total++;
      if (bus3.req_ready_o !== 3'b010) begin
         bad++; $display("FAIL wrap_grant1 got=%b exp=010", bus3.req_ready_o);
      end
      step();
      bus3.req_valid_i = 3'b000;
      total++;
      if (bus3.x_result_src_o !== 2'd1 || bus3.x_result_rd_o !== 5'd21) begin
         bad++; $display("FAIL wrap_out1 got src=%0d rd=%0d exp src=1 rd=21", bus3.x_result_src_o, bus3.x_result_rd_o);
      end
   endtask

   task automatic test_back_to_back();
      int         m_ptr;
      bit         m_valid;
      int         ntx;
      int         cyc;
      int         g;
      int         idx;
      logic [1:0] v;
      logic       rdy;
      logic [1:0] exp_rr;
      item_t      exp_it;
      item_t      obs;
      m_ptr = 0; m_valid = 0; ntx = 0; cyc = 0;
      sb_q.delete();
      do_reset();
      while (ntx < 100 && cyc < 3000) begin
         total++;
         if (bus2.x_result_valid_o !== m_valid) begin
            bad++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, bus2.x_result_valid_o, m_valid);
         end
         v   = 2'($urandom_range(0, 3));
         rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            set_lane2(i, 4'($urandom), 5'($urandom), 1'((cyc + i) % 2), $urandom);
         end
         bus2.req_valid_i = v;
         bus2.x_result_ready_i = rdy;
         #1;
         g = -1;
         for (int k = 0; k < 2; k++) begin
            idx = (m_ptr + k) % 2;
            if (g < 0 && v[idx]) g = idx;
         end
         exp_rr = ((!m_valid || rdy) && g >= 0) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
         total++;
         if (bus2.req_ready_o !== exp_rr) begin
            bad++; $display("FAIL b2b_req_ready cyc=%0d got=%b exp=%b", cyc, bus2.req_ready_o, exp_rr);
         end
         if (m_valid && rdy) begin
            obs.r.id = bus2.x_result_id_o;
            obs.r.rd = bus2.x_result_rd_o;
            obs.r.we = bus2.x_result_we_o;
            obs.r.data = bus2.x_result_data_o;
            obs.src = bus2.x_result_src_o;
            total++;
            if (sb_q.size() == 0) begin
               bad++; $display("FAIL b2b_unexpected cyc=%0d got=%h exp=none", cyc, obs);
            end else begin
               exp_it = sb_q.pop_front();
               if (obs !== exp_it) begin
                  bad++; $display("FAIL b2b_result cyc=%0d got=%h exp=%h", cyc, obs, exp_it);
               end
            end
         end
         if (exp_rr != 2'b00) begin
            exp_it.r.id   = bus2.req_id_i[g*4 +: 4];
            exp_it.r.rd   = bus2.req_rd_i[g*5 +: 5];
            exp_it.r.we   = bus2.req_we_i[g];
            exp_it.r.data = bus2.req_data_i[g*32 +: 32];
            exp_it.src    = 1'(g);
            sb_q.push_back(exp_it);
            m_ptr   = (g + 1) % 2;
            m_valid = 1;
            ntx++;
         end else if (rdy) begin
            m_valid = 0;
         end
         step();
         cyc++;
      end
      total++;
      if (ntx < 100) begin
         bad++; $display("FAIL b2b_timeout got=%0d exp=100 transactions", ntx);
      end
      bus2.req_valid_i = 2'b00;
      bus2.x_result_ready_i = 1'b1;
      for (int c = 0; c < 4 && sb_q.size() > 0; c++) begin
         obs.r.id = bus2.x_result_id_o;
         obs.r.rd = bus2.x_result_rd_o;
         obs.r.we = bus2.x_result_we_o;
         obs.r.data = bus2.x_result_data_o;
         obs.src = bus2.x_result_src_o;
         exp_it = sb_q.pop_front();
         total++;
         if (bus2.x_result_valid_o !== 1'b1 || obs !== exp_it) begin
            bad++; $display("FAIL b2b_drain got v=%b %h exp v=1 %h", bus2.x_result_valid_o, obs, exp_it);
         end
         step();
      end
      total++;
      if (sb_q.size() != 0 || bus2.x_result_valid_o !== 1'b0) begin
         bad++; $display("FAIL b2b_final got pending=%0d v=%b exp pending=0 v=0", sb_q.size(), bus2.x_result_valid_o);
      end
   endtask

   initial begin
      bus2.req_valid_i = '0;
      bus2.req_id_i = '0;
      bus2.req_rd_i = '0;
      bus2.req_we_i = '0;
      bus2.req_data_i = '0;
      bus2.x_result_ready_i = 1'b1;
      bus3.req_valid_i = '0;
      bus3.req_id_i = '0;
      bus3.req_rd_i = '0;
      bus3.req_we_i = '0;
      bus3.req_data_i = '0;
      bus3.x_result_ready_i = 1'b1;
      test_reset();
      test_alternate();
      test_single();
      test_stall();
      test_wrap3();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
